console_lamp_scan_ctrl: RTL and testbench
=========================================

// Module: console_lamp_scan_ctrl
// PURPOSE
//  Sequencer for the console lamp matrix built on the N-type control light driver cards
//  (inverting drivers, input low = lamp lit). Time-multiplexes N_GROUPS x GROUP_W lamp
//  states onto one GROUP_W driver bus plus one-cold group selects. Adds blink, LAMP TEST
//  override and a power-on lamp walk. Sits between CPU/console status latches and the drivers.
// PARAMETERS
//  N_GROUPS   4   lamp groups scanned (>=2)
//  GROUP_W    8   lamps per group = driver inputs per group
//  DWELL      16  clocks each group is driven (>=1)
//  BLANK      2   all-off clocks before each group, anti-ghosting (>=1)
//  BLINK_DIV  8   scan frames per blink half-period (>=1)
// PORTS
//  clk          in   1                 system clock, all logic rising edge
//  reset        in   1                 synchronous, active-high
//  lamp_state   in   N_GROUPS*GROUP_W  1 = lamp on; lamp i -> group i/GROUP_W, bit i%GROUP_W
//  blink_mask   in   N_GROUPS*GROUP_W  1 = lamp blinks when lamp_state is 1
//  lamp_test    in   1                 level; 1 = force all lamps lit
//  walk_start   in   1                 1-clk pulse; start lamp walk test
//  drv_n        out  GROUP_W           driver inputs, 0 = lit
//  grp_sel_n    out  N_GROUPS          one-cold group enable, 0 = selected
//  walk_busy    out  1                 1 while walk test runs
//  frame_tick   out  1                 1-clk pulse at end of each full scan frame
// BEHAVIOUR
//  Reset: state S_BLANK, grp=0, dwell/blank counters 0, frame cnt 0, blink phase 0 (lit),
//   walk idx 0; drv_n all 1, grp_sel_n all 1, walk_busy 0, frame_tick 0. All outputs registered.
//  FSM: S_BLANK (BLANK clks; drv_n, grp_sel_n all 1) -> S_DRIVE (DWELL clks; grp_sel_n[grp]=0,
//   others 1) -> grp+1 (wrap N_GROUPS-1 -> 0) -> S_BLANK. No other states; never stalls.
//  Frame = N_GROUPS*(BLANK+DWELL) clks (72 default). First S_DRIVE outputs for group 0 visible
//   BLANK clks after first edge with reset low, held DWELL clks.
//  Data capture: group word computed once on S_BLANK->S_DRIVE edge, held constant for whole
//   dwell; input changes mid-dwell appear next visit of that group.
//  Lit bit (before inversion), priority high->low:
//   lamp_test=1        -> 1 for every lamp
//   walk_busy=1        -> 1 only for lamp index == walk idx
//   else               -> lamp_state & ~(blink_mask & blink phase)
//  frame_tick: asserted the clk the last group's dwell ends (grp wraps to 0).
//  Blink: frame cnt increments per frame_tick; at BLINK_DIV it clears and blink phase toggles.
//   Phase 1 = blinking lamps dark. Full blink period = 2*BLINK_DIV frames.
//  Walk: walk_start while walk_busy=0 -> walk_busy=1 on next clk, walk idx=0; walk idx
//   advances on each frame_tick; after frame_tick with idx=N_GROUPS*GROUP_W-1, walk_busy=0,
//   idx=0. walk_start while busy ignored. Walk only alters what is lit, not scan timing.
//  lamp_test during walk: all lit, walk keeps advancing underneath.
//  Simultaneous walk_start and frame_tick: walk starts, idx=0 (tick not counted).
//  Reset mid-frame/mid-walk: immediate return to reset values next edge; walk aborted.
//  Never more than one grp_sel_n low; grp_sel_n and drv_n change only on state edges.
// TESTING
//  1 Reset 3 clks, lamp_state=0 -> drv_n=8'hFF, grp_sel_n=4'hF through reset; grp_sel_n=4'hE
//    exactly 2 clks after reset release, held 16 clks; frame_tick every 72 clks.
//  2 lamp_state bit 9 only -> group 1 drv_n=8'hFD, groups 0/2/3 drv_n=8'hFF; change bit 9 to 0
//    mid group-1 dwell -> drv_n stays 8'hFD until dwell ends.
//  3 lamp_state bit 0 + blink_mask bit 0 -> lamp 0 lit 8 frames, dark 8 frames, repeating;
//    non-blink lamp bit 1 lit continuously.
//  4 lamp_test=1 with lamp_state=0 -> every group drv_n=8'h00; drop lamp_test -> 8'hFF from
//    next group capture.
//  5 walk_start pulse -> walk_busy=1 next clk; frame k lights only lamp k; walk_busy=0 after
//    32nd frame_tick; second walk_start while busy has no effect.
//  6 reset asserted mid-walk during group 2 dwell -> all outputs at reset values next edge,
//    walk_busy=0, scan restarts at group 0.

Source files
------------

// File: rtl/console_lamp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : console_lamp_scan_ctrl
// Description : Scan sequencer for the console lamp matrix on inverting
//               (input low = lamp lit) control light driver cards.
//               Time-multiplexes N_GROUPS x GROUP_W lamp states onto one
//               GROUP_W driver bus with one-cold group selects. Each group
//               gets BLANK all-off clocks followed by DWELL driven clocks.
//               Adds per-lamp blink, a LAMP TEST override and a lamp walk.
// Ports       : clk         system clock, rising edge
//               reset       synchronous, active-high
//               lamp_state  1 = lamp on (lamp i -> group i/GROUP_W, bit i%GROUP_W)
//               blink_mask  1 = lamp blinks while its lamp_state bit is 1
//               lamp_test   level, 1 = every lamp lit
//               walk_start  one-clock pulse, starts the lamp walk
//               drv_n       driver inputs, 0 = lit
//               grp_sel_n   one-cold group enable, 0 = selected
//               walk_busy   1 while the lamp walk runs
//               frame_tick  one-clock pulse at the end of every scan frame
// Revision    : 1.0 - initial release
// ============================================================================
module console_lamp_scan_ctrl #(
  parameter int N_GROUPS  = 4,
  parameter int GROUP_W   = 8,
  parameter int DWELL     = 16,
  parameter int BLANK     = 2,
  parameter int BLINK_DIV = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_GROUPS*GROUP_W-1:0]   lamp_state,
  input  logic [N_GROUPS*GROUP_W-1:0]   blink_mask,
  input  logic                          lamp_test,
  input  logic                          walk_start,
  output logic [GROUP_W-1:0]            drv_n,
  output logic [N_GROUPS-1:0]           grp_sel_n,
  output logic                          walk_busy,
  output logic                          frame_tick
);

  localparam int C_N_LAMPS = N_GROUPS * GROUP_W;
  localparam int C_CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam int C_GRP_W   = $clog2(N_GROUPS);
  localparam int C_FRM_W   = $clog2(BLINK_DIV + 1);
  localparam int C_IDX_W   = $clog2(C_N_LAMPS);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_GRP_W-1:0]   grp_q, grp_d;
  logic [C_FRM_W-1:0]   frm_q, frm_d;
  logic                 phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic [C_IDX_W-1:0]   idx_q, idx_d;
  logic [GROUP_W-1:0]   drv_n_q, drv_n_d;
  logic [N_GROUPS-1:0]  sel_n_q, sel_n_d;
  logic                 tick_q, tick_d;

  // Per-group views of the flat lamp vectors, plus the walk pattern for
  // every group, so the active group can be picked with a plain array index.
  logic [GROUP_W-1:0]   w_state_grp [N_GROUPS];
  logic [GROUP_W-1:0]   w_blink_grp [N_GROUPS];
  logic [GROUP_W-1:0]   w_walk_grp  [N_GROUPS];

  for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_grp
    assign w_state_grp[gi] = lamp_state[gi*GROUP_W +: GROUP_W];
    assign w_blink_grp[gi] = blink_mask[gi*GROUP_W +: GROUP_W];
    for (genvar bi = 0; bi < GROUP_W; bi++) begin : g_bit
      assign w_walk_grp[gi][bi] = (idx_q == C_IDX_W'(gi*GROUP_W + bi));
    end
  end

  logic                 w_blank_done;
  logic                 w_dwell_done;
  logic                 w_last_grp;
  logic                 w_frame_end;
  logic [GROUP_W-1:0]   w_lit;

  assign w_blank_done = (state_q == S_BLANK) && (cnt_q == C_CNT_W'(BLANK - 1));
  assign w_dwell_done = (state_q == S_DRIVE) && (cnt_q == C_CNT_W'(DWELL - 1));
  assign w_last_grp   = (grp_q == C_GRP_W'(N_GROUPS - 1));
  assign w_frame_end  = w_dwell_done && w_last_grp;

  // Lit pattern for the group about to be driven: lamp test beats the walk,
  // the walk beats normal status display.
  always_comb begin
    w_lit = w_state_grp[grp_q] & ~(w_blink_grp[grp_q] & {GROUP_W{phase_q}});
    if (lamp_test) begin
      w_lit = {GROUP_W{1'b1}};
    end else if (busy_q) begin
      w_lit = w_walk_grp[grp_q];
    end
  end

  // Scan FSM next state and registered output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    grp_d   = grp_q;
    drv_n_d = drv_n_q;
    sel_n_d = sel_n_q;
    tick_d  = w_frame_end;
    case (state_q)
      S_BLANK: begin
        if (w_blank_done) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          // Group word is frozen here for the whole dwell.
          drv_n_d = ~w_lit;
          sel_n_d = ~(N_GROUPS'(1) << grp_q);
        end
      end
      S_DRIVE: begin
        if (w_dwell_done) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          grp_d   = w_last_grp ? '0 : grp_q + 1'b1;
          drv_n_d = '1;
          sel_n_d = '1;
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
        drv_n_d = '1;
        sel_n_d = '1;
      end
    endcase
  end

  // Blink divider and lamp walk, both paced by frame ends.
  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    idx_d   = idx_q;
    if (w_frame_end) begin
      if (frm_q == C_FRM_W'(BLINK_DIV - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d   = frm_q + 1'b1;
      end
    end
    // A start coinciding with a frame end wins: the walk begins at lamp 0.
    if (walk_start && !busy_q) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end else if (busy_q && w_frame_end) begin
      if (idx_q == C_IDX_W'(C_N_LAMPS - 1)) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      grp_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      drv_n_q <= '1;
      sel_n_q <= '1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      drv_n_q <= drv_n_d;
      sel_n_q <= sel_n_d;
      tick_q  <= tick_d;
    end
  end

  assign drv_n      = drv_n_q;
  assign grp_sel_n  = sel_n_q;
  assign walk_busy  = busy_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_console_lamp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_lamp_scan_ctrl
// Description : Self-checking bench for console_lamp_scan_ctrl. A frame-slot
//               reference model predicts every output each cycle; directed
//               literal checks pin reset, timing, blink, lamp test, walk and
//               mid-walk reset behaviour; a randomized phase mixes inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_lamp_scan_ctrl;

  localparam int NG    = 4;
  localparam int GW    = 8;
  localparam int DW    = 16;
  localparam int BL    = 2;
  localparam int BDIV  = 8;
  localparam int NL    = NG * GW;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = NG * SLOT;

  logic            clk;
  logic            reset;
  logic [NL-1:0]   lamp_state;
  logic [NL-1:0]   blink_mask;
  logic            lamp_test;
  logic            walk_start;
  logic [GW-1:0]   drv_n;
  logic [NG-1:0]   grp_sel_n;
  logic            walk_busy;
  logic            frame_tick;

  console_lamp_scan_ctrl #(
    .N_GROUPS (NG),
    .GROUP_W  (GW),
    .DWELL    (DW),
    .BLANK    (BL),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lamp_state(lamp_state),
    .blink_mask(blink_mask),
    .lamp_test (lamp_test),
    .walk_start(walk_start),
    .drv_n     (drv_n),
    .grp_sel_n (grp_sel_n),
    .walk_busy (walk_busy),
    .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in the frame is simply (edges since reset) mod FRAME; each
  // group occupies SLOT edges: BL blank ones followed by DW driven ones.
  int              m_n     = 0;
  int              m_frm   = 0;
  bit              m_phase = 1'b0;
  bit              m_busy  = 1'b0;
  int              m_idx   = 0;
  bit              m_valid = 1'b0;
  logic [GW-1:0]   e_drv;
  logic [NG-1:0]   e_sel;
  logic            e_tick;

  task automatic model_step();
    int nn, slot, g, o, l;
    bit fe;
    logic [GW-1:0] w;
    logic [NG-1:0] one;
    if (reset) begin
      m_n = 0; m_frm = 0; m_phase = 1'b0; m_busy = 1'b0; m_idx = 0;
      e_drv = '1; e_sel = '1; e_tick = 1'b0; m_valid = 1'b1;
    end else begin
      nn   = m_n + 1;
      slot = nn % FRAME;
      g    = slot / SLOT;
      o    = slot % SLOT;
      fe   = (slot == 0);
      w    = '0;
      one  = 1;
      if (o == BL) begin
        for (int b = 0; b < GW; b++) begin
          l = g * GW + b;
          if (lamp_test)   w[b] = 1'b1;
          else if (m_busy) w[b] = (l == m_idx);
          else             w[b] = (((lamp_state >> l) & 1) != 0) &&
                                  !((((blink_mask >> l) & 1) != 0) && m_phase);
        end
        e_drv = ~w;
        e_sel = ~(one << g);
      end else if (o < BL) begin
        e_drv = '1;
        e_sel = '1;
      end
      e_tick = fe;
      if (fe) begin
        m_frm++;
        if (m_frm == BDIV) begin
          m_frm   = 0;
          m_phase = ~m_phase;
        end
      end
      if (walk_start && !m_busy) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end else if (m_busy && fe) begin
        m_idx++;
        if (m_idx == NL) begin
          m_busy = 1'b0;
          m_idx  = 0;
        end
      end
      m_n = nn;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("drv_n", drv_n, e_drv);
        chk("grp_sel_n", grp_sel_n, e_sel);
        chk("walk_busy", walk_busy, m_busy);
        chk("frame_tick", frame_tick, e_tick);
        chk("one_cold", ($countones(~grp_sel_n) <= 1), 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_sel(input logic [NG-1:0] v, input string nm);
    int t;
    t = 0;
    while (grp_sel_n == v && t < 400) begin @(negedge clk); t++; end
    while (grp_sel_n != v && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting for grp_sel_n, actual %h required %h", nm, grp_sel_n, v);
    end
  endtask

  task automatic wait_tick(input string nm, input int exp_cyc);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_tick && c < 200);
    chk(nm, c, exp_cyc);
  endtask

  initial begin
    int ticks, cyc;
    reset = 1'b1; lamp_state = '0; blink_mask = '0; lamp_test = 1'b0; walk_start = 1'b0;

    // 1: reset values and scan timing
    repeat (3) @(negedge clk);
    chk("rst_drv", drv_n, 8'hFF);
    chk("rst_sel", grp_sel_n, 4'hF);
    chk("rst_busy", walk_busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("sel_blank1", grp_sel_n, 4'hF);
    @(negedge clk);
    chk("sel_grp0_first", grp_sel_n, 4'hE);
    wait_tick("first_tick_cycle", 70);
    wait_tick("tick_period", FRAME);

    // 2: single lamp and mid-dwell capture hold
    lamp_state = 32'h0000_0200;
    wait_sel(4'hD, "wait_g1");
    chk("g1_lamp9", drv_n, 8'hFD);
    repeat (5) @(negedge clk);
    lamp_state = '0;
    repeat (5) @(negedge clk);
    chk("g1_hold", drv_n, 8'hFD);
    wait_sel(4'hD, "wait_g1b");
    chk("g1_cleared", drv_n, 8'hFF);

    // 3: blink from a known phase
    reset = 1'b1; lamp_state = 32'h3; blink_mask = 32'h1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 3 * BDIV; f++) begin
      wait_sel(4'hE, "wait_blink");
      chk("blink_frame", drv_n, ((f / BDIV) % 2 != 0) ? 8'hFD : 8'hFC);
    end

    // 4: lamp test
    blink_mask = '0; lamp_state = '0; lamp_test = 1'b1;
    wait_sel(4'hE, "wait_lt0"); chk("lt_g0", drv_n, 8'h00);
    wait_sel(4'hD, "wait_lt1"); chk("lt_g1", drv_n, 8'h00);
    wait_sel(4'hB, "wait_lt2"); chk("lt_g2", drv_n, 8'h00);
    wait_sel(4'h7, "wait_lt3"); chk("lt_g3", drv_n, 8'h00);
    lamp_test = 1'b0;
    wait_sel(4'hE, "wait_lt_off"); chk("lt_off", drv_n, 8'hFF);

    // 5: lamp walk started mid-frame, with a retrigger while busy
    lamp_state = '1;
    wait_sel(4'hB, "wait_walk");
    repeat (3) @(negedge clk);
    walk_start = 1'b1;
    @(negedge clk);
    walk_start = 1'b0;
    chk("walk_busy_set", walk_busy, 1);
    ticks = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      walk_start = (cyc == 500);
      if (frame_tick) ticks++;
      if (ticks == 9 && grp_sel_n == 4'hD) chk("walk_lamp9", drv_n, 8'hFD);
    end while (walk_busy && cyc < 40 * FRAME);
    walk_start = 1'b0;
    chk("walk_ticks", ticks, NL);

    // 6: randomized mix
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lamp_state = $urandom;
      blink_mask = $urandom;
      if ($urandom_range(0, 199) == 0) lamp_test = ~lamp_test;
      walk_start = ($urandom_range(0, 999) == 0);
    end
    lamp_test = 1'b0; walk_start = 1'b0;

    // 7: reset mid-walk during group 2 dwell
    @(negedge clk);
    walk_start = 1'b1;
    @(negedge clk);
    walk_start = 1'b0;
    chk("walk2_busy", walk_busy, 1);
    wait_sel(4'hB, "wait_g2");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_drv", drv_n, 8'hFF);
    chk("mid_rst_sel", grp_sel_n, 4'hF);
    chk("mid_rst_busy", walk_busy, 0);
    chk("mid_rst_tick", frame_tick, 0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("restart_grp0", grp_sel_n, 4'hE);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lamp_state = $urandom;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
